// File: rtl/multibuffer_unpack_queue.sv
// multibuffer_unpack_queue: wide-entry queue returning one narrow lane per read, with per-entry lane counts
module multibuffer_unpack_queue #(
  parameter int IN_WIDTH = 128,
  parameter int OUT_WIDTH = 42,
  parameter int LANES = 2,
  parameter int LANE_STRIDE = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int AFULL_MARGIN = 4,
  localparam int LCW = $clog2(LANES) + 1,
  localparam int LW = $clog2(LANES),
  localparam int LVW = DEPTH_LOG2 + 1,
  localparam int DEPTH = 1 << DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [IN_WIDTH-1:0]   data_in,
  input  logic [LCW-1:0]        write_lanes,
  output logic                  waitrequest,
  input  logic                  read_en,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic [LW-1:0]         data_lane,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level
);
  logic [IN_WIDTH-1:0] mem_q [DEPTH];
  logic [LCW-1:0] cnt_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] lane_q, lane_d, dlane_q, dlane_d;
  logic [LVW-1:0] level_q, level_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic valid_q, afull_q, afull_d;
  logic wr_acc, rd_acc, rd_last;
  logic [LCW-1:0] wcnt;
  assign full = level_q == LVW'(DEPTH);
  assign empty = level_q == '0;
  assign waitrequest = full;
  assign level = level_q;
  assign data_out = data_q;
  assign data_lane = dlane_q;
  assign data_valid = valid_q;
  assign almost_full = afull_q;
  always_comb begin
    wr_acc = write_en && !full && write_lanes != '0 && !flush;
    rd_acc = read_en && !empty && !flush;
    wcnt = write_lanes > LCW'(LANES) ? LCW'(LANES) : write_lanes;
    rd_last = LCW'(lane_q) == cnt_q[rptr_q] - LCW'(1);
    wptr_d = flush ? '0 : wptr_q + DEPTH_LOG2'(wr_acc);
    rptr_d = flush ? '0 : rptr_q + DEPTH_LOG2'(rd_acc && rd_last);
    lane_d = flush ? '0 : !rd_acc ? lane_q : rd_last ? '0 : lane_q + LW'(1);
    level_d = flush ? '0 : level_q + LVW'(wr_acc) - LVW'(rd_acc && rd_last);
    afull_d = level_d >= LVW'(DEPTH - AFULL_MARGIN);
    data_d = rd_acc ? mem_q[rptr_q][lane_q*LANE_STRIDE +: OUT_WIDTH] : '0;
    dlane_d = rd_acc ? lane_q : '0;
  end
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= data_in;
      cnt_q[wptr_q] <= wcnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lane_q <= '0;
      level_q <= '0;
      data_q <= '0;
      dlane_q <= '0;
      valid_q <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lane_q <= lane_d;
      level_q <= level_d;
      data_q <= data_d;
      dlane_q <= dlane_d;
      valid_q <= rd_acc;
      afull_q <= afull_d;
    end
  end
endmodule

// File: tb/tb_multibuffer_unpack_queue.sv
// tb_multibuffer_unpack_queue: directed self-checking bench for multibuffer_unpack_queue
module tb_multibuffer_unpack_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic write_en = 1'b0;
  logic [127:0] data_in = '0;
  logic [1:0] write_lanes = '0;
  logic waitrequest;
  logic read_en = 1'b0;
  logic [41:0] data_out;
  logic [0:0] data_lane;
  logic data_valid, full, empty, almost_full;
  logic [4:0] level;
  int checks = 0;
  int failures = 0;
  multibuffer_unpack_queue #(.DEPTH_LOG2(4), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .data_in(data_in),
    .write_lanes(write_lanes), .waitrequest(waitrequest), .read_en(read_en),
    .data_out(data_out), .data_lane(data_lane), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] pack(input logic [41:0] a, input logic [41:0] b);
    logic [127:0] p;
    p = '1;
    p[41:0] = a;
    p[105:64] = b;
    return p;
  endfunction
  task automatic wr(input logic [41:0] a, input logic [41:0] b, input logic [1:0] n);
    write_en = 1'b1;
    data_in = pack(a, b);
    write_lanes = n;
    step();
    write_en = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [41:0] d, input logic l);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk({tag, "_valid"}, 64'(data_valid), 64'd1);
    chk({tag, "_data"}, 64'(data_out), 64'(d));
    chk({tag, "_lane"}, 64'(data_lane), 64'(l));
  endtask
  initial begin
    step();
    step();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_wait", 64'(waitrequest), 64'd0);
    rst = 1'b0;
    wr(42'h111, 42'h222, 2'd2);
    chk("a_level", 64'(level), 64'd1);
    chk("a_empty", 64'(empty), 64'd0);
    rd("a0", 42'h111, 1'b0);
    chk("a0_level", 64'(level), 64'd1);
    rd("a1", 42'h222, 1'b1);
    chk("a1_level", 64'(level), 64'd0);
    chk("a1_empty", 64'(empty), 64'd1);
    step();
    chk("idle_valid", 64'(data_valid), 64'd0);
    chk("idle_data", 64'(data_out), 64'd0);
    wr(42'h5A, 42'h77, 2'd1);
    wr(42'h99, 42'h88, 2'd0);
    chk("drop_level", 64'(level), 64'd1);
    wr(42'h01, 42'h02, 2'd3);
    chk("clamp_level", 64'(level), 64'd2);
    rd("b0", 42'h5A, 1'b0);
    chk("b0_level", 64'(level), 64'd1);
    rd("b1", 42'h01, 1'b0);
    rd("b2", 42'h02, 1'b1);
    chk("b_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 16; i++) begin
      wr(42'(12'h100 + 2*i), 42'(12'h101 + 2*i), 2'd2);
      chk("fill_level", 64'(level), 64'(i + 1));
      chk("fill_af", 64'(almost_full), 64'(i + 1 >= 14));
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_wait", 64'(waitrequest), 64'd1);
    wr(42'hDEAD, 42'hBEEF, 2'd2);
    chk("over_level", 64'(level), 64'd16);
    for (int e = 0; e < 16; e++) begin
      rd("drain0", 42'(12'h100 + 2*e), 1'b0);
      rd("drain1", 42'(12'h101 + 2*e), 1'b1);
      chk("drain_level", 64'(level), 64'(15 - e));
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_af", 64'(almost_full), 64'd0);
    for (int e = 0; e < 5; e++) wr(42'(12'h300 + 2*e), 42'(12'h301 + 2*e), 2'd2);
    chk("c_level", 64'(level), 64'd5);
    rd("c0", 42'h300, 1'b0);
    write_en = 1'b1;
    data_in = pack(42'h30A, 42'h30B);
    write_lanes = 2'd2;
    read_en = 1'b1;
    step();
    write_en = 1'b0;
    read_en = 1'b0;
    chk("c_same_level", 64'(level), 64'd5);
    chk("c_same_data", 64'(data_out), 64'h301);
    chk("c_same_lane", 64'(data_lane), 64'd1);
    for (int e = 1; e < 6; e++) begin
      rd("c_d0", 42'(12'h300 + 2*e), 1'b0);
      rd("c_d1", 42'(12'h301 + 2*e), 1'b1);
    end
    chk("c_empty", 64'(empty), 64'd1);
    for (int e = 0; e < 8; e++) wr(42'(12'h400 + e), 42'(12'h480 + e), 2'd2);
    rd("f0", 42'h400, 1'b0);
    chk("f_level", 64'(level), 64'd8);
    flush = 1'b1;
    write_en = 1'b1;
    data_in = pack(42'h777, 42'h778);
    write_lanes = 2'd2;
    read_en = 1'b1;
    step();
    flush = 1'b0;
    write_en = 1'b0;
    read_en = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_af", 64'(almost_full), 64'd0);
    chk("flush_valid", 64'(data_valid), 64'd0);
    wr(42'hABC, 42'hDEF, 2'd2);
    rd("pf0", 42'hABC, 1'b0);
    rd("pf1", 42'hDEF, 1'b1);
    for (int e = 0; e < 14; e++) wr(42'(12'h500 + e), 42'(12'h580 + e), 2'd2);
    chk("f2_af", 64'(almost_full), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f2_af_clr", 64'(almost_full), 64'd0);
    chk("f2_level", 64'(level), 64'd0);
    for (int e = 0; e < 3; e++) wr(42'(12'h600 + e), 42'(12'h680 + e), 2'd2);
    read_en = 1'b1;
    step();
    chk("r_s0", 64'(data_out), 64'h600);
    step();
    chk("r_s1", 64'(data_out), 64'h680);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_valid", 64'(data_valid), 64'd0);
    chk("r_data", 64'(data_out), 64'd0);
    chk("r_level", 64'(level), 64'd0);
    step();
    chk("r_empty_rd0", 64'(data_valid), 64'd0);
    step();
    chk("r_empty_rd1", 64'(data_valid), 64'd0);
    read_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multibuffer_unpack_queue.md
Name: multibuffer_unpack_queue

Overview:
- Parametrised queue that accepts wide packed words and returns them as narrower sub-word lanes, one lane per read.
- Each written entry carries its own valid-lane count, so partially filled words are unpacked without padding reads.
- Adds exact entry-level full/almost_full thresholds, an occupancy output and a synchronous flush.
- Sits between a wide packet producer and a narrow consumer in the FIFO datapath.

Parameters:
IN_WIDTH, 128, width of data_in
OUT_WIDTH, 42, width of one lane / data_out
LANES, 2, sub-word lanes per entry; lane k = data_in[k*LANE_STRIDE +: OUT_WIDTH]
LANE_STRIDE, 64, bit offset between lane bases; must be >= OUT_WIDTH, and LANES*LANE_STRIDE <= IN_WIDTH
DEPTH_LOG2, 10, log2 of entry capacity; DEPTH = 2**DEPTH_LOG2
AFULL_MARGIN, 4, almost_full asserts when level >= DEPTH - AFULL_MARGIN
(LCW = $clog2(LANES)+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of queue contents
write_en  in  1  write request
data_in  in  IN_WIDTH  packed entry
write_lanes  in  LCW  number of valid lanes in data_in (lanes 0..n-1)
waitrequest  out  1  write not accepted this cycle (= full)
read_en  in  1  read request for one lane
data_out  out  OUT_WIDTH  lane data, valid when data_valid
data_lane  out  $clog2(LANES)  lane index of data_out
data_valid  out  1  data_out valid
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  registered threshold flag
level  out  DEPTH_LOG2+1  stored entries, including the partially read head

Behaviour:
- Reset (rst=1 at a clk edge): write/read pointers, lane index and level are 0; data_valid=0; data_out=0; data_lane=0; almost_full=0; full=0; empty=1. Reset mid-operation discards all contents.
- Write accept = write_en & !full & write_lanes != 0 & !flush. An accepted write stores data_in and clamps write_lanes to LANES, writes at the write pointer, and increments the pointer (wraps modulo DEPTH). A write with write_lanes==0 is dropped: no allocation, no error.
- Read accept = read_en & !empty & !flush. An accepted read targets the head entry at the current lane index.
  - If lane index == head count-1: the read pointer advances, lane index returns to 0 and the entry is freed.
  - Otherwise the lane index increments.
- The head lane count is held in a flop array so it is available combinationally.
- Latency: data_valid=1 exactly one cycle after an accepted read, otherwise 0 (no bubbles inserted for back-to-back reads). data_out/data_lane carry the read lane in that cycle; data_out=0 whenever data_valid=0.
- Level: +1 on an accepted write; -1 on an accepted read that frees an entry; unchanged when both occur in the same cycle. full and empty are decoded combinationally from level. There is no truncated-compare slack: full means exactly DEPTH entries.
- A write accepted in cycle t is readable from cycle t+1 (empty deasserts at t+1). RAM read-during-write to the same address never occurs, because the head is never the write slot unless empty.
- almost_full: registered each cycle from the next-state level >= DEPTH-AFULL_MARGIN, so it matches the level on the same clock.
- flush (rst=0): behaves as reset for pointers, level, lane index and flags on the next edge. It takes priority over a same-cycle write/read, neither of which is accepted. data_valid from a read accepted in the previous cycle still presents in the flush cycle.
- A write while full: ignored, and the state is unchanged. A read while empty: ignored, and data_valid=0 next cycle.

Test Plan:
(All scenarios use DEPTH_LOG2=4, AFULL_MARGIN=2, LANES=2, defaults otherwise.)
- Reset then write A (data_in[41:0]=0x111, [105:64]=0x222, lanes=2), then read x2 -> data_valid pulses on the two following cycles with 0x111 (lane 0) then 0x222 (lane 1); empty returns to 1 after the second read; level goes 0->1->1->0.
- Write with lanes=1 (lane0=0x5A), then lanes=0, then lanes=3 (lane0=0x01, lane1=0x02) -> reads return 0x5A, 0x01, 0x02; the lanes=0 write is dropped; the lanes=3 write is clamped to 2; level peaks at 2.
- Write 16 entries -> full=1 and waitrequest=1 at level 16; almost_full=1 from level 14. A 17th write is ignored. Drain all 32 lanes in order, with the pointer wrap checked on a second fill.
- Level 5, and in the same cycle a write is accepted and a lane-1 read frees the head -> level stays 5; the data order is preserved.
- Level 8 mid-entry (lane index 1), assert flush with write_en and read_en high -> next cycle level=0, empty=1, almost_full=0; the next write/read pair returns the new data at lane 0.
- Assert rst during a back-to-back read stream -> data_valid=0 and data_out=0 on the following cycle; a subsequent read_en with no writes produces no data_valid.
